// File: rtl/rns_pkg.sv
// Shared RNS definitions: address width, per-domain residue width and the
// packed residue-word width helper. Used by the store queue and data memory.
package rns_pkg;

  localparam int unsigned DATA_ADDR_W = 8;
  localparam int unsigned RESIDUE_W   = 8;

  // Width of a full residue word: one byte per domain, Domain1 in the MSBs.
  function automatic int unsigned word_w(input int unsigned num_domains);
    return num_domains * RESIDUE_W;
  endfunction

endpackage

// File: rtl/sq_fwd_match.sv
// Store-to-load forwarding match for rns_store_queue.
// Compares the load address against every occupied entry and returns the
// data of the youngest match (the entry closest to tail).
// Ports:
//   ent_addr_i / ent_data_i : entry address / residue-word arrays
//   occ_i                   : per-entry occupancy
//   tail_i                  : next write slot (youngest entry is tail-1)
//   ld_addr_i               : load read address
//   ld_hit_o                : any occupied entry matches
//   ld_fwd_data_o           : youngest matching data, 0 when no match
module sq_fwd_match
  import rns_pkg::*;
#(
  parameter int unsigned WORD_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic [DATA_ADDR_W-1:0]     ent_addr_i [DEPTH],
  input  logic [WORD_W-1:0]          ent_data_i [DEPTH],
  input  logic [DEPTH-1:0]           occ_i,
  input  logic [$clog2(DEPTH)-1:0]   tail_i,
  input  logic [DATA_ADDR_W-1:0]     ld_addr_i,
  output logic                       ld_hit_o,
  output logic [WORD_W-1:0]          ld_fwd_data_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] idx;
  logic             found;

  // Walk from youngest (tail-1) to oldest; the first match wins.
  always_comb begin
    found         = 1'b0;
    idx           = '0;
    ld_fwd_data_o = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = tail_i - PTR_W'(k + 1);
      if (!found && occ_i[idx] && (ent_addr_i[idx] == ld_addr_i)) begin
        found         = 1'b1;
        ld_fwd_data_o = ent_data_i[idx];
      end
    end
    ld_hit_o = found;
  end

endmodule

// File: rtl/rns_store_queue.sv
// In-order store queue feeding the RNS data memory write port, with
// store-to-load forwarding of the youngest pending data.
// Ports:
//   clk, reset                : clock, async active-low reset
//   st_valid/st_ready/st_addr/st_data : store enqueue handshake
//   drain_hold                : inhibit draining this cycle
//   data_wr_addr/datamem_wr_data/store_to_mem : memory write port (head entry)
//   ld_addr/ld_hit/ld_fwd_data: load forwarding
//   sq_empty/sq_count         : occupancy status
module rns_store_queue
  import rns_pkg::*;
#(
  parameter int unsigned NUM_DOMAINS = 1,
  parameter int unsigned DEPTH       = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                st_valid,
  output logic                                st_ready,
  input  logic [DATA_ADDR_W-1:0]              st_addr,
  input  logic [word_w(NUM_DOMAINS)-1:0]      st_data,
  input  logic                                drain_hold,
  output logic [DATA_ADDR_W-1:0]              data_wr_addr,
  output logic [word_w(NUM_DOMAINS)-1:0]      datamem_wr_data,
  output logic                                store_to_mem,
  input  logic [DATA_ADDR_W-1:0]              ld_addr,
  output logic                                ld_hit,
  output logic [word_w(NUM_DOMAINS)-1:0]      ld_fwd_data,
  output logic                                sq_empty,
  output logic [$clog2(DEPTH+1)-1:0]          sq_count
);

  localparam int unsigned WORD_W = word_w(NUM_DOMAINS);
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

  logic [DATA_ADDR_W-1:0] addr_q [DEPTH];
  logic [WORD_W-1:0]      data_q [DEPTH];
  logic [PTR_W-1:0]       head_q, head_d;
  logic [PTR_W-1:0]       tail_q, tail_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [DEPTH-1:0]       occ;
  logic [PTR_W-1:0]       rel;
  logic                   enq;
  logic                   deq;

  // Status and handshake derive from registered count only.
  assign sq_empty     = (count_q == '0);
  assign sq_count     = count_q;
  assign st_ready     = (count_q != CNT_W'(DEPTH));
  assign store_to_mem = !sq_empty && !drain_hold;
  assign enq          = st_valid && st_ready;
  assign deq          = store_to_mem;

  assign data_wr_addr    = sq_empty ? '0 : addr_q[head_q];
  assign datamem_wr_data = sq_empty ? '0 : data_q[head_q];

  // Pointer and occupancy next-state.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (enq) tail_d = tail_q + PTR_W'(1);
    if (deq) head_d = head_q + PTR_W'(1);
    count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage, written at tail on accept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else if (enq) begin
      addr_q[tail_q] <= st_addr;
      data_q[tail_q] <= st_data;
    end
  end

  // Entry i is occupied when its distance from head is below count.
  always_comb begin
    occ = '0;
    rel = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      rel    = PTR_W'(i) - head_q;
      occ[i] = (CNT_W'(rel) < count_q);
    end
  end

  sq_fwd_match #(
    .WORD_W (WORD_W),
    .DEPTH  (DEPTH)
  ) u_fwd (
    .ent_addr_i    (addr_q),
    .ent_data_i    (data_q),
    .occ_i         (occ),
    .tail_i        (tail_q),
    .ld_addr_i     (ld_addr),
    .ld_hit_o      (ld_hit),
    .ld_fwd_data_o (ld_fwd_data)
  );

endmodule

// File: tb/tb_rns_store_queue.sv
module tb_rns_store_queue;

  logic        clk;
  logic        reset;

  // Instance A: NUM_DOMAINS = 1, DEPTH = 4
  logic        a_st_valid, a_st_ready, a_hold, a_wr_en, a_ld_hit, a_empty;
  logic [7:0]  a_st_addr, a_st_data, a_wr_addr, a_wr_data, a_ld_addr, a_fwd;
  logic [2:0]  a_count;

  // Instance B: NUM_DOMAINS = 2, DEPTH = 4
  logic        b_st_valid, b_st_ready, b_hold, b_wr_en, b_ld_hit, b_empty;
  logic [7:0]  b_st_addr, b_wr_addr, b_ld_addr;
  logic [15:0] b_st_data, b_wr_data, b_fwd;
  logic [2:0]  b_count;

  int n_checks;
  int n_fail;

  rns_store_queue #(.NUM_DOMAINS(1), .DEPTH(4)) dut_a (
    .clk(clk), .reset(reset),
    .st_valid(a_st_valid), .st_ready(a_st_ready), .st_addr(a_st_addr), .st_data(a_st_data),
    .drain_hold(a_hold), .data_wr_addr(a_wr_addr), .datamem_wr_data(a_wr_data),
    .store_to_mem(a_wr_en), .ld_addr(a_ld_addr), .ld_hit(a_ld_hit), .ld_fwd_data(a_fwd),
    .sq_empty(a_empty), .sq_count(a_count)
  );

  rns_store_queue #(.NUM_DOMAINS(2), .DEPTH(4)) dut_b (
    .clk(clk), .reset(reset),
    .st_valid(b_st_valid), .st_ready(b_st_ready), .st_addr(b_st_addr), .st_data(b_st_data),
    .drain_hold(b_hold), .data_wr_addr(b_wr_addr), .datamem_wr_data(b_wr_data),
    .store_to_mem(b_wr_en), .ld_addr(b_ld_addr), .ld_hit(b_ld_hit), .ld_fwd_data(b_fwd),
    .sq_empty(b_empty), .sq_count(b_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a_reset_vals(input string tag);
    check_eq({tag, " st_ready"},  32'(a_st_ready), 32'h1);
    check_eq({tag, " sq_empty"},  32'(a_empty),    32'h1);
    check_eq({tag, " sq_count"},  32'(a_count),    32'h0);
    check_eq({tag, " store_to_mem"}, 32'(a_wr_en), 32'h0);
    check_eq({tag, " ld_hit"},    32'(a_ld_hit),   32'h0);
    check_eq({tag, " ld_fwd"},    32'(a_fwd),      32'h0);
    check_eq({tag, " wr_addr"},   32'(a_wr_addr),  32'h0);
    check_eq({tag, " wr_data"},   32'(a_wr_data),  32'h0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b0;
    a_st_valid = 1'b0; a_st_addr = '0; a_st_data = '0; a_hold = 1'b0; a_ld_addr = 8'h10;
    b_st_valid = 1'b0; b_st_addr = '0; b_st_data = '0; b_hold = 1'b0; b_ld_addr = 8'h05;

    // Reset values
    #12;
    check_a_reset_vals("rst");
    check_eq("rst b sq_empty", 32'(b_empty), 32'h1);
    check_eq("rst b wr_data",  32'(b_wr_data), 32'h0);
    step();
    reset = 1'b1;
    step();

    // Single store 0x10 <- 0xA5, written the cycle after accept
    a_st_valid = 1'b1; a_st_addr = 8'h10; a_st_data = 8'hA5;
    #1;
    check_eq("single st_ready", 32'(a_st_ready), 32'h1);
    check_eq("single no early wr", 32'(a_wr_en), 32'h0);
    check_eq("single not visible same cycle", 32'(a_ld_hit), 32'h0);
    step();
    a_st_valid = 1'b0;
    #1;
    check_eq("single wr_en",   32'(a_wr_en),   32'h1);
    check_eq("single wr_addr", 32'(a_wr_addr), 32'h10);
    check_eq("single wr_data", 32'(a_wr_data), 32'hA5);
    check_eq("single head fwd hit",  32'(a_ld_hit), 32'h1);
    check_eq("single head fwd data", 32'(a_fwd),    32'hA5);
    step();
    check_eq("single empty after", 32'(a_empty), 32'h1);
    check_eq("single wr_en after", 32'(a_wr_en), 32'h0);

    // Fill with hold: 4 accepted, 5th refused
    a_hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a_st_valid = 1'b1; a_st_addr = 8'(8'h30 + i); a_st_data = 8'(8'h40 + i);
      #1;
      check_eq($sformatf("fill st_ready %0d", i), 32'(a_st_ready), (i < 4) ? 32'h1 : 32'h0);
      check_eq($sformatf("fill wr_en held %0d", i), 32'(a_wr_en), 32'h0);
      step();
    end
    a_st_valid = 1'b0;
    #1;
    check_eq("fill count", 32'(a_count), 32'h4);
    a_ld_addr = 8'h32;
    #1;
    check_eq("fill fwd hit",  32'(a_ld_hit), 32'h1);
    check_eq("fill fwd data", 32'(a_fwd),    32'h42);
    a_ld_addr = 8'h34;
    #1;
    check_eq("fill refused store not fwd", 32'(a_ld_hit), 32'h0);
    a_hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq($sformatf("drain wr_en %0d", i),   32'(a_wr_en),   32'h1);
      check_eq($sformatf("drain wr_addr %0d", i), 32'(a_wr_addr), 32'(8'h30 + i));
      check_eq($sformatf("drain wr_data %0d", i), 32'(a_wr_data), 32'(8'h40 + i));
      step();
    end
    check_eq("drain empty", 32'(a_empty), 32'h1);

    // Youngest-match forwarding
    a_hold = 1'b1; a_ld_addr = 8'h20;
    a_st_valid = 1'b1; a_st_addr = 8'h20; a_st_data = 8'h11;
    step();
    a_st_data = 8'h22;
    #1;
    check_eq("fwd older only", 32'(a_fwd), 32'h11);
    step();
    a_st_valid = 1'b0;
    #1;
    check_eq("fwd young hit",  32'(a_ld_hit), 32'h1);
    check_eq("fwd young data", 32'(a_fwd),    32'h22);
    a_ld_addr = 8'h21;
    #1;
    check_eq("fwd miss hit",  32'(a_ld_hit), 32'h0);
    check_eq("fwd miss data", 32'(a_fwd),    32'h0);
    a_hold = 1'b0;
    #1;
    check_eq("fwd drain0 data", 32'(a_wr_data), 32'h11);
    step();
    check_eq("fwd drain1 data", 32'(a_wr_data), 32'h22);
    step();
    check_eq("fwd drained", 32'(a_empty), 32'h1);

    // Continuous enqueue + drain
    a_st_valid = 1'b1; a_st_addr = 8'h50; a_st_data = 8'h60;
    step();
    for (int k = 1; k <= 10; k++) begin
      a_st_addr = 8'(8'h50 + k); a_st_data = 8'(8'h60 + k);
      #1;
      check_eq($sformatf("stream count %0d", k),   32'(a_count),   32'h1);
      check_eq($sformatf("stream wr_en %0d", k),   32'(a_wr_en),   32'h1);
      check_eq($sformatf("stream wr_addr %0d", k), 32'(a_wr_addr), 32'(8'h50 + k - 1));
      check_eq($sformatf("stream wr_data %0d", k), 32'(a_wr_data), 32'(8'h60 + k - 1));
      step();
    end
    a_st_valid = 1'b0;
    #1;
    check_eq("stream last addr", 32'(a_wr_addr), 32'h5A);
    step();
    check_eq("stream empty", 32'(a_empty), 32'h1);

    // Reset with 3 pending stores
    a_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_st_valid = 1'b1; a_st_addr = 8'(8'h70 + i); a_st_data = 8'(8'h80 + i);
      step();
    end
    a_st_valid = 1'b0; a_hold = 1'b0; a_ld_addr = 8'h71;
    #1;
    check_eq("prerst count", 32'(a_count), 32'h3);
    check_eq("prerst wr_en", 32'(a_wr_en), 32'h1);
    #1;
    reset = 1'b0;
    #1;
    check_a_reset_vals("midrst");
    step();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq($sformatf("postrst no wr %0d", i), 32'(a_wr_en), 32'h0);
      step();
    end

    // Two-domain word
    b_hold = 1'b1;
    b_st_valid = 1'b1; b_st_addr = 8'h05; b_st_data = {8'h03, 8'h04};
    step();
    b_st_valid = 1'b0;
    #1;
    check_eq("nd2 fwd hit",  32'(b_ld_hit), 32'h1);
    check_eq("nd2 fwd data", 32'(b_fwd),    32'h0304);
    b_hold = 1'b0;
    #1;
    check_eq("nd2 wr_en",   32'(b_wr_en),   32'h1);
    check_eq("nd2 wr_addr", 32'(b_wr_addr), 32'h05);
    check_eq("nd2 wr_data", 32'(b_wr_data), 32'h0304);
    step();
    check_eq("nd2 empty", 32'(b_empty), 32'h1);
    check_eq("nd2 count", 32'(b_count), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rns_store_queue.md
# rns_store_queue

Store queue sitting directly upstream of the RNS data memory write port. It accepts STORE operations from the execute stage and buffers up to DEPTH of them. It drains them in order into the data memory write port. Loads whose address matches a pending store receive the youngest pending data by forwarding, so loads never read stale memory. Each entry holds one 8-bit address plus the full NUM_DOMAINS-byte residue word, so no residue conversion happens here.

## Interface
- NUM_DOMAINS, 1, number of RNS residue domains per word (byte per domain, Domain1 in MSBs)
- DEPTH, 4, queue entries; power of two, ≥2

- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- st_valid  in  1  execute stage presents a store
- st_ready  out  1  queue can accept a store this cycle
- st_addr  in  8  store address
- st_data  in  NUM_DOMAINS*8  store residue word
- drain_hold  in  1  inhibits draining this cycle
- data_wr_addr  out  8  to data memory write address
- datamem_wr_data  out  NUM_DOMAINS*8  to data memory write data
- store_to_mem  out  1  to data memory write enable
- ld_addr  in  8  current load read address
- ld_hit  out  1  a pending store matches ld_addr
- ld_fwd_data  out  NUM_DOMAINS*8  youngest matching pending data
- sq_empty  out  1  no pending stores (fence indication)
- sq_count  out  $clog2(DEPTH+1)  number of pending stores

## Operation
- Circular buffer of DEPTH entries {addr, data}, with head (oldest) and tail pointers. Each pointer is $clog2(DEPTH) bits and wraps modulo DEPTH.
- Occupancy is held in count, 0..DEPTH.
- Enqueue when st_valid && st_ready. The entry is written at tail, tail increments, and count increments.
- st_ready = (count != DEPTH), from registered count only. A full queue refuses a store even in a cycle where it drains.
- Drain:
  - store_to_mem = !sq_empty && !drain_hold.
  - data_wr_addr and datamem_wr_data show the head entry.
  - When store_to_mem = 1, head increments at the same edge at which memory captures the write.
- Simultaneous enqueue and drain: count is unchanged and both pointers advance.
- When empty, data_wr_addr and datamem_wr_data read 0.
- Forwarding (combinational):
  - ld_addr is compared against every occupied entry.
  - ld_hit = 1 if any entry matches; ld_fwd_data is the data of the youngest match (closest to tail).
  - With no match, ld_hit = 0 and ld_fwd_data = 0.
  - The head entry being written this cycle still forwards, because memory only holds the value after the edge.
- The store accepted in the current cycle is not visible to forwarding until the next cycle.
- Addresses are exact 8-bit compares; no partial-domain matching.

## Timing
- Reset (async assert, synchronous release):
  - count = 0 and head = tail = 0; pending stores are discarded.
  - Outputs: st_ready = 1, sq_empty = 1, sq_count = 0, store_to_mem = 0, ld_hit = 0, and all data/address outputs 0.
- Reset asserted mid-operation discards pending stores without writing them. No partial write is issued after assertion.
- Latency: a store accepted at edge N into an empty queue drives store_to_mem during cycle N→N+1 and is written to memory at edge N+1, provided drain_hold = 0.
- Throughput: one enqueue and one drain per cycle sustained.
- With drain_hold held high, the queue fills to DEPTH; st_ready falls in the cycle after the DEPTH-th accept.
- st_ready, sq_empty, sq_count and store_to_mem depend only on registers plus drain_hold. They have no combinational path from st_valid.

## Structure
- Shared package rns_pkg holds DATA_ADDR_W = 8 and RESIDUE_W = 8, and the function word_w(NUM_DOMAINS) = NUM_DOMAINS*RESIDUE_W. The data memory uses the same package.
- One sub-module, sq_fwd_match:
  - Inputs: entry addr/data arrays, an occupancy vector derived from head/count, tail, and ld_addr.
  - Outputs: ld_hit and ld_fwd_data, using a priority select from the youngest entry downward.

## Test plan
- Reset, then a single store at addr 0x10, data 0xA5 (NUM_DOMAINS=1): store_to_mem = 1 the next cycle with addr 0x10 and data 0xA5; sq_empty returns to 1 after that edge.
- drain_hold = 1 and 5 stores offered to a DEPTH = 4 queue: 4 are accepted and st_ready = 0 on the 5th. Releasing hold gives 4 in-order writes on consecutive cycles.
- Stores 0x20←0x11 then 0x20←0x22 pending with hold high, and ld_addr = 0x20: ld_hit = 1 and ld_fwd_data = 0x22. With ld_addr = 0x21: ld_hit = 0 and ld_fwd_data = 0.
- Continuous enqueue+drain for 10 cycles: sq_count stays 1, pointers wrap past DEPTH, and write order matches enqueue order.
- Reset asserted with 3 pending stores: outputs go to reset values immediately and no further store_to_mem pulses occur.
- NUM_DOMAINS = 2, store 0x05←{0x03,0x04}: datamem_wr_data = 0x0304, and a forward at ld_addr 0x05 returns 0x0304.
